// File: rtl/wshb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter.
// No logic of its own; pick_grant() is the round-robin decision used from IDLE and HANDOVER.
// Backpressure: not applicable.
package wshb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GNT0     = 2'd1,
      GNT1     = 2'd2,
      HANDOVER = 2'd3
   } arb_state_t;

   localparam int MAX_ACKS_DEF = 16;

   // A lone requester wins outright; on a tie the master that was not served last wins.
   function automatic arb_state_t pick_grant(input logic req0, input logic req1, input logic last);
      arb_state_t nxt;
      nxt = IDLE;
      if (req0 && req1) begin
         nxt = last ? GNT0 : GNT1;
      end else if (req0) begin
         nxt = GNT0;
      end else if (req1) begin
         nxt = GNT1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/wshb_arbiter.sv
// Round-robin arbiter letting the VGA reader (m0) and the mire writer (m1) share one Wishbone slave.
// Latency: grant 1 cycle after cyc is sampled in IDLE/HANDOVER; ack and read data pass through combinationally.
// Backpressure: a waiting master simply holds cyc/stb; the holder is preempted only on an ack boundary.
module wshb_arbiter
   import wshb_arb_pkg::*;
#(
   parameter int  AW       = 32,
   parameter int  DW       = 32,
   parameter int  MAX_ACKS = MAX_ACKS_DEF,
   localparam int SW       = DW / 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_cyc,
   input  logic          m0_stb,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_adr,
   input  logic [DW-1:0] m0_dat,
   input  logic [SW-1:0] m0_sel,
   output logic          m0_ack,
   output logic [DW-1:0] m0_dat_r,
   input  logic          m1_cyc,
   input  logic          m1_stb,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_adr,
   input  logic [DW-1:0] m1_dat,
   input  logic [SW-1:0] m1_sel,
   output logic          m1_ack,
   output logic [DW-1:0] m1_dat_r,
   output logic          s_cyc,
   output logic          s_stb,
   output logic          s_we,
   output logic [AW-1:0] s_adr,
   output logic [DW-1:0] s_dat,
   output logic [SW-1:0] s_sel,
   input  logic          s_ack,
   input  logic [DW-1:0] s_dat_r
);

   localparam int            CW      = $clog2(MAX_ACKS + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_ACKS);
   localparam logic [CW-1:0] PRE_CNT = CW'(MAX_ACKS - 1);

   arb_state_t    state_q, state_d;
   logic          last_q, last_d;
   logic [CW-1:0] ack_cnt_q, ack_cnt_d;
   logic          own_cyc;
   logic          oth_cyc;
   logic          at_limit;

   // Next-state: grant decision, release/preemption detection and per-grant ack counting.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      ack_cnt_d = ack_cnt_q;
      own_cyc   = (state_q == GNT1) ? m1_cyc : m0_cyc;
      oth_cyc   = (state_q == GNT1) ? m0_cyc : m1_cyc;
      // The counter climbs one step at a time and saturates, so it passes through PRE_CNT
      // before sitting at MAX_CNT; either value means the current ack uses up the budget.
      at_limit  = (ack_cnt_q == PRE_CNT) || (ack_cnt_q == MAX_CNT);

      case (state_q)
         IDLE, HANDOVER: begin
            state_d = pick_grant(m0_cyc, m1_cyc, last_q);
         end
         GNT0, GNT1: begin
            if (s_ack && (ack_cnt_q != MAX_CNT)) begin
               ack_cnt_d = ack_cnt_q + CW'(1);
            end
            if (!own_cyc || (oth_cyc && s_ack && at_limit)) begin
               state_d = HANDOVER;
               last_d  = (state_q == GNT1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Every fresh grant starts with a full ack budget.
      if ((state_d != state_q) && ((state_d == GNT0) || (state_d == GNT1))) begin
         ack_cnt_d = '0;
      end
   end

   // State, round-robin pointer and ack counter registers; reset leaves m0 first in line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         ack_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         ack_cnt_q <= ack_cnt_d;
      end
   end

   // Slave-side mux and ack routing from the registered grant; idle and handover drive zeros.
   always_comb begin
      s_cyc  = 1'b0;
      s_stb  = 1'b0;
      s_we   = 1'b0;
      s_adr  = '0;
      s_dat  = '0;
      s_sel  = '0;
      m0_ack = 1'b0;
      m1_ack = 1'b0;
      case (state_q)
         GNT0: begin
            s_cyc  = m0_cyc;
            s_stb  = m0_stb;
            s_we   = m0_we;
            s_adr  = m0_adr;
            s_dat  = m0_dat;
            s_sel  = m0_sel;
            m0_ack = s_ack;
         end
         GNT1: begin
            s_cyc  = m1_cyc;
            s_stb  = m1_stb;
            s_we   = m1_we;
            s_adr  = m1_adr;
            s_dat  = m1_dat;
            s_sel  = m1_sel;
            m1_ack = s_ack;
         end
         default: begin
         end
      endcase
   end

   // Read data is broadcast; only the granted master sees an ack qualifying it.
   assign m0_dat_r = s_dat_r;
   assign m1_dat_r = s_dat_r;

endmodule
